// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer for the shared mux_Q1 unit.
// Two requesters hand over {op, x, y}; one command is in flight at a time.
// The result is returned with the requester ID over a valid/ready channel.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; the grant is issued from here
// EXEC  | dp_* stable, mux_Q1 output settles; captured at the edge
// RESP  | resp_valid held with resp_z/resp_id until resp_ready
module alu_share_ctrl #(
  parameter int IDW  = 1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [1:0]      a_op,
  input  logic [7:0]      a_x,
  input  logic [7:0]      a_y,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [1:0]      b_op,
  input  logic [7:0]      b_x,
  input  logic [7:0]      b_y,
  output logic [1:0]      dp_s0,
  output logic [7:0]      dp_x,
  output logic [7:0]      dp_y,
  input  logic [7:0]      dp_z,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [7:0]      resp_z,
  output logic            busy,
  output logic [CNTW-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           grant_a;
  logic           grant_b;
  logic           last_grant;
  logic [IDW-1:0] cur_id;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration and next-state: ties go to the requester not served last
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_valid && (!b_valid || last_grant)) grant_a = 1'b1;
        else if (b_valid)                        grant_b = 1'b1;
        if (grant_a || grant_b) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are masked while reset is held so nothing looks accepted
  assign a_ready = grant_a && rst_n;
  assign b_ready = grant_b && rst_n;
  assign busy    = (state != IDLE);

  // Command capture: operands are sampled only on the granting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s0      <= 2'b00;
      dp_x       <= 8'd0;
      dp_y       <= 8'd0;
      cur_id     <= '0;
      last_grant <= 1'b1;
    end else if (grant_a) begin
      dp_s0      <= a_op;
      dp_x       <= a_x;
      dp_y       <= a_y;
      cur_id     <= IDW'(0);
      last_grant <= 1'b0;
    end else if (grant_b) begin
      dp_s0      <= b_op;
      dp_x       <= b_x;
      dp_y       <= b_y;
      cur_id     <= IDW'(1);
      last_grant <= 1'b1;
    end
  end

  // Response capture, hold under backpressure, and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_z     <= 8'd0;
      ops_done   <= '0;
    end else if (state == EXEC) begin
      resp_valid <= 1'b1;
      resp_id    <= cur_id;
      resp_z     <= dp_z;
    end else if ((state == RESP) && resp_ready) begin
      resp_valid <= 1'b0;
      ops_done   <= ops_done + CNTW'(1);
    end
  end

endmodule
